// File: rtl/cv32e41s_sffr_mon_pkg.sv
// Shared types and default parameters for the sffr integrity monitor.
package cv32e41s_sffr_mon_pkg;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    SUSPECT = 2'b01,
    FATAL   = 2'b10
  } sffr_state_e;

  localparam int unsigned SFFR_WIDTH  = 32;
  localparam int unsigned SFFR_THRESH = 3;
  localparam int unsigned SFFR_CNT_W  = 8;

  // The run counter only has to hold values up to THRESH-1.
  function automatic int unsigned run_width(input int unsigned thresh);
    return (thresh > 1) ? $clog2(thresh) : 1;
  endfunction

endpackage

// File: rtl/cv32e41s_sffr_mon_cmp.sv
// Registered primary/shadow compare stage. With CV32E41S_SFFR_MON_SYNDROME_EN
// defined it also captures the first mismatching bit pattern.
module cv32e41s_sffr_mon_cmp
  import cv32e41s_sffr_mon_pkg::*;
#(
  parameter int unsigned WIDTH = SFFR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] qs_i,
`ifdef CV32E41S_SFFR_MON_SYNDROME_EN
  input  logic             clr_i,
  output logic [WIDTH-1:0] syndrome_o,
`endif
  output logic             mis_q
);

  logic [WIDTH-1:0] diff;
  logic             any_diff;

  // The shadow bank is stored inverted, so a healthy bit XORs to 0 against ~qs.
  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_diff
    assign diff[gi] = q_i[gi] ^ ~qs_i[gi];
  end

  assign any_diff = |diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= en_i & any_diff;
    end
  end

`ifdef CV32E41S_SFFR_MON_SYNDROME_EN
  logic [WIDTH-1:0] syndrome_reg;
  logic             captured_reg;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      syndrome_reg <= '0;
      captured_reg <= 1'b0;
    end else if (!captured_reg && en_i && any_diff) begin
      syndrome_reg <= diff;
      captured_reg <= 1'b1;
    end
  end

  assign syndrome_o = syndrome_reg;
`endif

endmodule

// File: rtl/cv32e41s_sffr_mon.sv
// Integrity monitor for a hardened flip-flop bank and its inverted shadow.
// Optional syndrome capture port enabled by CV32E41S_SFFR_MON_SYNDROME_EN.
module cv32e41s_sffr_mon
  import cv32e41s_sffr_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = SFFR_WIDTH,
  parameter int unsigned THRESH = SFFR_THRESH,
  parameter int unsigned CNT_W  = SFFR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] qs_i,
  input  logic             clr_i,
  input  logic             alert_ack_i,
  output logic             alert_req_o,
  output logic             alert_major_o,
`ifdef CV32E41S_SFFR_MON_SYNDROME_EN
  output logic [WIDTH-1:0] syndrome_o,
`endif
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned         RUN_W    = run_width(THRESH);
  localparam logic [RUN_W-1:0]    RUN_LAST = RUN_W'(THRESH - 1);

  logic             mis_q;
  sffr_state_e      state_reg;
  logic [RUN_W-1:0] run_reg;
  logic             alert_req_reg;
  logic             alert_major_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic             run_last;
  logic             alert_evt;

  cv32e41s_sffr_mon_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .q_i        (q_i),
    .qs_i       (qs_i),
`ifdef CV32E41S_SFFR_MON_SYNDROME_EN
    .clr_i      (clr_i),
    .syndrome_o (syndrome_o),
`endif
    .mis_q      (mis_q)
  );

  assign run_last  = (run_reg == RUN_LAST);
  // Every mismatch seen in OK enters SUSPECT or FATAL; in SUSPECT only the
  // threshold-reaching one is a new event.
  assign alert_evt = mis_q & ((state_reg == OK) | ((state_reg == SUSPECT) & run_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= OK;
      run_reg         <= '0;
      alert_req_reg   <= 1'b0;
      alert_major_reg <= 1'b0;
    end else begin
      alert_req_reg <= alert_evt | (alert_req_reg & ~alert_ack_i);
      case (state_reg)
        OK: begin
          if (mis_q) begin
            if (THRESH == 1) begin
              state_reg       <= FATAL;
              alert_major_reg <= 1'b1;
            end else begin
              state_reg <= SUSPECT;
              run_reg   <= RUN_W'(1);
            end
          end else begin
            run_reg <= '0;
          end
        end
        SUSPECT: begin
          if (mis_q) begin
            if (run_last) begin
              state_reg       <= FATAL;
              alert_major_reg <= 1'b1;
            end else begin
              run_reg <= run_reg + 1'b1;
            end
          end else begin
            state_reg <= OK;
            run_reg   <= '0;
          end
        end
        FATAL: begin
          alert_major_reg <= 1'b1;
        end
        default: begin
          state_reg <= OK;
          run_reg   <= '0;
        end
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      err_cnt_reg <= '0;
    end else if (mis_q && (err_cnt_reg != {CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign alert_req_o   = alert_req_reg;
  assign alert_major_o = alert_major_reg;
  assign err_cnt_o     = err_cnt_reg;

endmodule

// File: tb/tb_cv32e41s_sffr_mon.sv
// Scoreboard bench for cv32e41s_sffr_mon (WIDTH=32, THRESH=3, CNT_W=4).
module tb_cv32e41s_sffr_mon;

  localparam logic [31:0] H_Q  = 32'hA5A5_0000;
  localparam logic [31:0] H_QS = 32'h5A5A_FFFF;
  localparam logic [31:0] F7   = H_QS ^ 32'h0000_0080;
  localparam logic [31:0] F0   = H_QS ^ 32'h0000_0001;

  typedef struct {
    logic       req;
    logic       major;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] q = H_Q;
  logic [31:0] qs = H_QS;
  logic        clr = 1'b0;
  logic        ack = 1'b0;
  logic        alert_req;
  logic        alert_major;
  logic [3:0]  err_cnt;
`ifdef CV32E41S_SFFR_MON_SYNDROME_EN
  logic [31:0] syndrome;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  always #5 clk = ~clk;

  cv32e41s_sffr_mon #(
    .WIDTH  (32),
    .THRESH (3),
    .CNT_W  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .q_i           (q),
    .qs_i          (qs),
    .clr_i         (clr),
    .alert_ack_i   (ack),
    .alert_req_o   (alert_req),
    .alert_major_o (alert_major),
`ifdef CV32E41S_SFFR_MON_SYNDROME_EN
    .syndrome_o    (syndrome),
`endif
    .err_cnt_o     (err_cnt)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic e, input logic [31:0] qsv,
                      input logic c, input logic a, input logic er,
                      input logic em, input logic [3:0] ec, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; q = H_Q; qs = qsv; clr = c; ack = a;
    x.req = er; x.major = em; x.cnt = ec; x.name = nm;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        txn++;
        if (alert_req !== mon_e.req || alert_major !== mon_e.major || err_cnt !== mon_e.cnt) begin
          errors++;
          $display("FAIL %s txn %0d: got req=%0b major=%0b cnt=%0d, expected req=%0b major=%0b cnt=%0d",
                   mon_e.name, txn, alert_req, alert_major, err_cnt, mon_e.req, mon_e.major, mon_e.cnt);
        end else begin
          $display("txn %0d %s: req=%0b major=%0b cnt=%0d ok", txn, mon_e.name,
                   alert_req, alert_major, err_cnt);
        end
      end
    end
  end

  initial begin : driver
    step(1, 1, H_QS, 0, 0, 0, 0, 4'd0, "reset0");
    step(1, 1, H_QS, 0, 0, 0, 0, 4'd0, "reset1");
    for (int i = 0; i < 100; i++) step(0, 1, H_QS, 0, 0, 0, 0, 4'd0, "healthy");

    // single-cycle fault on bit 7
    step(0, 1, F7,   0, 0, 0, 0, 4'd0, "sf_latency");
    step(0, 1, H_QS, 0, 0, 1, 0, 4'd1, "sf_alert");
    step(0, 1, H_QS, 0, 0, 1, 0, 4'd1, "sf_hold");
    step(0, 1, H_QS, 0, 1, 0, 0, 4'd1, "sf_ack");
    step(0, 1, H_QS, 0, 0, 0, 0, 4'd1, "sf_idle");
    step(0, 1, H_QS, 0, 1, 0, 0, 4'd1, "ack_no_pending");
    step(0, 1, H_QS, 1, 0, 0, 0, 4'd0, "clr");

    // persistent fault on bit 0, ack collides with FATAL entry
    step(0, 1, F0,   0, 0, 0, 0, 4'd0, "pf_latency");
    step(0, 1, F0,   0, 0, 1, 0, 4'd1, "pf_suspect");
    step(0, 1, F0,   0, 0, 1, 0, 4'd2, "pf_run2");
    step(0, 1, H_QS, 0, 1, 1, 1, 4'd3, "pf_fatal_ack_collide");
    step(0, 1, H_QS, 0, 0, 1, 1, 4'd3, "pf_hold");
    step(0, 1, H_QS, 0, 1, 0, 1, 4'd3, "pf_ack2");
    step(0, 1, H_QS, 1, 0, 0, 1, 4'd0, "pf_clr_sticky");
    step(0, 1, H_QS, 0, 0, 0, 1, 4'd0, "pf_sticky");

    // saturation while FATAL: count lags input by one edge, caps at 15
    for (int k = 0; k < 20; k++)
      step(0, 1, F7, 0, 0, 0, 1, (k > 15) ? 4'd15 : 4'(k), "saturate");
    step(0, 1, F7,   1, 0, 0, 1, 4'd0, "sat_clr_wins");
    step(0, 1, H_QS, 0, 0, 0, 1, 4'd1, "post_clr_count");
    step(0, 1, H_QS, 0, 0, 0, 1, 4'd1, "post_clr_idle");
    step(1, 1, H_QS, 0, 0, 0, 0, 4'd0, "rst_from_fatal");
    step(0, 1, H_QS, 0, 0, 0, 0, 4'd0, "after_rst");

    // compare disabled with mismatching inputs
    for (int i = 0; i < 5; i++) step(0, 0, F7, 0, 0, 0, 0, 4'd0, "en_low");
    step(0, 1, H_QS, 0, 0, 0, 0, 4'd0, "en_restore");
    step(0, 1, H_QS, 0, 0, 0, 0, 4'd0, "en_restore2");

    // reset while in SUSPECT, with a mismatch presented on the reset cycle
    step(0, 1, F0,   0, 0, 0, 0, 4'd0, "rs_latency");
    step(0, 1, F0,   0, 0, 1, 0, 4'd1, "rs_suspect");
    step(1, 1, F0,   0, 0, 0, 0, 4'd0, "rs_reset");
    step(0, 1, H_QS, 0, 0, 0, 0, 4'd0, "rs_after");
    step(0, 1, H_QS, 0, 0, 0, 0, 4'd0, "rs_after2");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cv32e41s_sffr_mon.md
# cv32e41s_sffr_mon

Integrity monitor that consumes the outputs of a bank of hardened security flip-flops and their complemented shadow copies. It flags any divergence between the two banks, counts mismatch cycles and escalates persistent faults to a sticky fatal alert. It sits directly downstream of the sffr register bank and upstream of the core alert/handshake logic.

## Interface
- WIDTH, 32: number of protected bits in each of the primary and shadow banks; must be ≥1.
- THRESH, 3: number of consecutive mismatch cycles that escalates to FATAL; must be ≥1.
- CNT_W, 8: width of the saturating mismatch-cycle counter.
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  compare enable; when low, the cycle counts as "no mismatch".
- q_i  in  WIDTH  primary bank outputs.
- qs_i  in  WIDTH  shadow bank outputs, stored inverted; a healthy bit satisfies qs_i == ~q_i.
- clr_i  in  1  clears err_cnt_o.
- alert_ack_i  in  1  acknowledge for alert_req_o.
- alert_req_o  out  1  minor/major alert request, held until acknowledged.
- alert_major_o  out  1  sticky fatal indication.
- err_cnt_o  out  CNT_W  saturating count of mismatch cycles.

## Operation
- Stage 1 compare: mis_q <= en_i & |(q_i ^ ~qs_i). This is registered, with no combinational path from the inputs to the FSM.
- Stage 2 FSM (state, run counter, outputs) acts on mis_q. Three states: OK, SUSPECT, FATAL.
- OK
  - mis_q=1 with THRESH=1 → FATAL.
  - mis_q=1 with THRESH>1 → SUSPECT, run=1.
  - otherwise stay in OK, run=0.
- SUSPECT
  - mis_q=1 and run+1==THRESH → FATAL.
  - mis_q=1 otherwise → run++.
  - mis_q=0 → OK, run=0.
- FATAL: absorbing; left only by rst. alert_major_o=1 in FATAL.
- err_cnt_o increments on every cycle where mis_q=1, in any state, and saturates at 2^CNT_W-1.
  - clr_i sets it to 0.
  - clr_i together with an increment in the same cycle → result 0 (clear wins).
  - clr_i does not affect state or alerts.
- Alert events are entry into SUSPECT and entry into FATAL.
  - An event sets alert_req_o.
  - alert_req_o clears in the cycle after alert_ack_i is sampled high while alert_req_o=1.
  - An event in the same cycle as an accepted ack keeps alert_req_o=1 (event wins).
  - An ack without a pending request is ignored.
  - Events occurring while a request is pending merge into the one request.
- en_i low: mis_q loads 0, so SUSPECT decays to OK one cycle later; FATAL persists.
- Reset: state=OK, run=0, mis_q=0, alert_req_o=0, alert_major_o=0, err_cnt_o=0. Reset mid-SUSPECT or in FATAL returns everything to these values on the next edge.

## Timing
- Mismatch presented in cycle n:
  - mis_q=1 after edge n.
  - State/err_cnt_o/alert_req_o update after edge n+1, i.e. outputs are visible 2 cycles after the input.
- FATAL is reached THRESH+1 edges after the first of THRESH consecutive mismatching input cycles.
- An ack sampled at edge k drops alert_req_o after edge k.
- All outputs are registered.

## Configuration
- CV32E41S_SFFR_MON_SYNDROME_EN
  - Defined: adds output syndrome_o (WIDTH), which captures q_i ^ ~qs_i of the first mismatching cycle after reset or clr_i. It is registered alongside mis_q and frozen until rst or clr_i. Reset value 0.
  - Undefined: the port and its registers are absent. All other behaviour is identical.

## Structure
- Package cv32e41s_sffr_mon_pkg holds:
  - the state enum (OK, SUSPECT, FATAL) with an explicit 2-bit encoding;
  - default constants for WIDTH, THRESH and CNT_W.
- Sub-module cv32e41s_sffr_mon_cmp: the registered XOR/OR-reduction stage (and the syndrome capture when enabled). It outputs mis_q.
- The FSM, run counter, error counter and handshake live in the top module.

## Test plan
- Healthy inputs: q_i=0xA5A5_0000, qs_i=0x5A5A_FFFF for 100 cycles → alert_req_o=0, alert_major_o=0, err_cnt_o=0.
- Single-cycle fault: flip bit 7 of qs_i for 1 cycle → 2 cycles later alert_req_o=1 and err_cnt_o=1; state returns to OK; alert_major_o=0; alert_ack_i pulse clears alert_req_o.
- Persistent fault with THRESH=3: flip bit 0 for 3 consecutive cycles → alert_major_o=1 at edge n+3, err_cnt_o=3; it stays 1 after the fault clears and after clr_i; only rst clears it.
- Saturation with CNT_W=4: 20 mismatch cycles → err_cnt_o=15. Then clr_i asserted in the same cycle as a further mismatch → err_cnt_o=0.
- Handshake collision: alert_ack_i high in the same cycle as the FSM entering FATAL → alert_req_o stays 1; a second ack clears it.
- en_i=0 with mismatching inputs → no counting, no alert. Also: rst asserted while in SUSPECT → all outputs 0 on the next edge.
